simon_round_key_sequencer: RTL



---
 rtl/simon_round_key_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/simon_round_key_sequencer.sv
// rtl/simon_round_key_sequencer.sv - Simon key-word state and round-key stream sequencer
//
// simon_key_schedule: combinational one-step Simon key expansion.
//    key_cur_i  in   [NKW-1:0][WW-1:0]  current key words (word 0 = oldest)
//    mode_i     in   1                  0 forward (encryption), 1 reverse (decryption)
//    c_xor_z_i  in   WW                 round constant c xor z-bit
//    key_nxt_o  out  [NKW-1:0][WW-1:0]  key words after one step
//
// simon_round_key_sequencer: owns the key registers and streams one round key per round.
//    clk_i, rst_i        clock, synchronous active-high reset
//    start_i, mode_i     begin a sequence (idle only), 0 enc / 1 dec
//    key_i               initial key words
//    rk_o, rk_valid_o, rk_ready_i, rk_last_o   round-key stream
//    busy_o, done_o      sequence in progress, pulse after final transfer

module simon_key_schedule #(
   parameter int WW  = 16,
   parameter int NKW = 4
) (
   input  logic [NKW-1:0][WW-1:0] key_cur_i,
   input  logic                   mode_i,
   input  logic [WW-1:0]          c_xor_z_i,
   output logic [NKW-1:0][WW-1:0] key_nxt_o
);

   function automatic logic [WW-1:0] ror(input logic [WW-1:0] x, input int r);
      return (x >> r) | (x << (WW - r));
   endfunction

   logic [WW-1:0] hi;
   logic [WW-1:0] side;
   logic [WW-1:0] tmp;

   // Forward: new word from k_i, k_{i+m-1}, k_{i+1}. Reverse runs the same
   // recurrence backwards, so the roles of words 1 and NKW-1 swap.
   always_comb begin
      hi   = mode_i ? key_cur_i[1] : key_cur_i[NKW-1];
      side = mode_i ? key_cur_i[NKW-1] : key_cur_i[1];
      tmp  = ror(hi, 3);
      if (NKW == 4) begin
         tmp = tmp ^ side;
      end
      tmp = tmp ^ ror(tmp, 1);
      for (int j = 0; j < NKW - 1; j++) begin
         key_nxt_o[j] = key_cur_i[j+1];
      end
      key_nxt_o[NKW-1] = c_xor_z_i ^ key_cur_i[0] ^ tmp;
   end

endmodule

module simon_round_key_sequencer #(
   parameter int WW   = 16,
   parameter int NKW  = 4,
   parameter int NR   = 32,
   parameter int ZIDX = 0
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic                   mode_i,
   input  logic [NKW-1:0][WW-1:0] key_i,
   output logic [WW-1:0]          rk_o,
   output logic                   rk_valid_o,
   input  logic                   rk_ready_i,
   output logic                   rk_last_o,
   output logic                   busy_o,
   output logic                   done_o
);

   localparam int              CW       = (NR > 1) ? $clog2(NR) : 1;
   localparam logic [CW-1:0]   LAST_CNT = CW'(NR - 1);
   localparam logic [CW-1:0]   PREV_CNT = CW'(NR - 2);
   localparam int              ZDEC_I   = ((NR - 1 - NKW) % 62 + 62) % 62;
   localparam logic [5:0]      ZDEC     = 6'(ZDEC_I);

   // Bit 61 of each constant is z_j index 0 (leftmost character of the sequence).
   function automatic logic [61:0] z_table(input int idx);
      case (idx)
         1:       return 62'b10001110111110010011000010110101000111011111001001100001011010;
         2:       return 62'b10101111011100000011010010011000101000010001111110010110110011;
         3:       return 62'b11011011101011000110010111100000010010001010011100110100001111;
         4:       return 62'b11010001111001101011011000100000010111000011001010010011101111;
         default: return 62'b11111010001001010110000111001101111101000100101011000011100110;
      endcase
   endfunction

   localparam logic [61:0] Z_SEQ = z_table(ZIDX);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                 state_q;
   logic [NKW-1:0][WW-1:0] key_q;
   logic [NKW-1:0][WW-1:0] key_nxt;
   logic [CW-1:0]          cnt_q;
   logic [5:0]             zptr_q;
   logic                   mode_q;
   logic                   last_q;
   logic                   done_q;
   logic                   zbit;
   logic [WW-1:0]          c_xor_z;

   assign zbit    = Z_SEQ[6'd61 - zptr_q];
   assign c_xor_z = {{(WW-2){1'b1}}, 1'b0, zbit};

   simon_key_schedule #(
      .WW  (WW),
      .NKW (NKW)
   ) u_sched (
      .key_cur_i (key_q),
      .mode_i    (mode_q),
      .c_xor_z_i (c_xor_z),
      .key_nxt_o (key_nxt)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         key_q   <= '0;
         cnt_q   <= '0;
         zptr_q  <= '0;
         mode_q  <= 1'b0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  state_q <= RUN;
                  key_q   <= key_i;
                  mode_q  <= mode_i;
                  cnt_q   <= '0;
                  zptr_q  <= mode_i ? ZDEC : 6'd0;
                  last_q  <= (NR == 1);
               end
            end
            RUN: begin
               if (rk_ready_i) begin
                  key_q <= key_nxt;
                  if (mode_q) begin
                     zptr_q <= (zptr_q == 6'd0) ? 6'd61 : zptr_q - 6'd1;
                  end else begin
                     zptr_q <= (zptr_q == 6'd61) ? 6'd0 : zptr_q + 6'd1;
                  end
                  if (cnt_q == LAST_CNT) begin
                     // Counter parks at 0 rather than stepping past NR-1.
                     state_q <= IDLE;
                     cnt_q   <= '0;
                     last_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     cnt_q  <= cnt_q + 1'b1;
                     last_q <= (cnt_q == PREV_CNT);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rk_o       = key_q[0];
   assign rk_valid_o = (state_q == RUN);
   assign busy_o     = (state_q == RUN);
   assign rk_last_o  = last_q;
   assign done_o     = done_q;

endmodule
